axis8to32: RTL and testbench
============================

AXIS8TO32 -- requirements
Module: axis8to32

Interface
REQ-001 Parameter: LSB_FIRST, 1, 1 = first accepted byte of a word lands in s_data[7:0]; 0 = first byte lands in s_data[31:24].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstf  input  1  asynchronous, active-low reset.
REQ-004 m_data  input  8  input byte stream data.
REQ-005 m_valid  input  1  input byte valid.
REQ-006 m_ready  output  1  block accepts byte this cycle.
REQ-007 m_last  input  1  input byte is final byte of packet; qualifies m_data when m_valid high.
REQ-008 s_data  output  32  packed output word.
REQ-009 s_keep  output  4  per-byte-lane valid mask of s_data; bit i covers s_data[8i+7:8i].
REQ-010 s_last  output  1  output word carries final byte of packet.
REQ-011 s_valid  output  1  output word valid.
REQ-012 s_ready  input  1  downstream accepts word this cycle.

Function
REQ-013 Byte accepted when m_valid && m_ready; word accepted when s_valid && s_ready.
REQ-014 m_ready SHALL equal (~s_valid | s_ready); combinational, no dependence on m_valid.
REQ-015 2-bit lane counter cnt (0..3) selects destination lane of next accepted byte; it increments by 1 per accepted byte and wraps 3->0.
REQ-016 With LSB_FIRST=1, byte at cnt=k goes to lane k; with LSB_FIRST=0, it goes to lane 3-k.
REQ-017 Accepted bytes at cnt=0..2 with m_last=0 are held in an internal accumulator and do not change the s_* outputs.
REQ-018 An accepted byte with cnt=3 or m_last=1 completes the word: on that same clock edge the accumulator plus the current byte loads into the output register, s_valid=1, and cnt resets to 0.
REQ-019 Latency: s_valid SHALL rise on the clock edge that accepts the completing byte, so the word is visible in the following cycle.
REQ-020 A full word sets s_keep=4'hF; a partial word completed by m_last at cnt=k sets s_keep to k+1 contiguous ones starting at the first-byte lane (LSB_FIRST=1: 4'b0001, 4'b0011, 4'b0111).
REQ-021 Lanes with s_keep=0 SHALL read 8'h00 in s_data.
REQ-022 s_last SHALL equal the m_last of the completing byte; m_last at cnt=3 gives s_keep=4'hF with s_last=1.
REQ-023 The accumulator is cleared to zero whenever a word is loaded, so no stale bytes leak into the next word.
REQ-024 s_data, s_keep, s_last and s_valid SHALL remain stable while s_valid && ~s_ready.
REQ-025 On word acceptance with no completing byte on the same edge, s_valid goes 0; s_data, s_keep and s_last hold their values.
REQ-026 Simultaneous word acceptance and completing-byte acceptance SHALL load the new word with s_valid staying 1, giving sustained throughput of 1 word per 4 byte cycles with no bubble.
REQ-027 When s_valid && ~s_ready, m_ready=0 and cnt and the accumulator hold.
REQ-028 m_data and m_last are ignored when m_valid=0.

Reset
REQ-029 Asserting rstf=0 SHALL immediately force cnt=0, accumulator=0, s_valid=0, s_data=32'h0, s_keep=4'h0 and s_last=0, regardless of clk.
REQ-030 Reset mid-word discards the partially accumulated bytes, and the first byte accepted after reset goes to the first-byte lane.
REQ-031 Deasserting rstf SHALL be synchronous to clk externally; the block needs no post-reset idle cycles.

Verification
REQ-032 LSB_FIRST=1; bytes 11,22,33,44 with m_last on 44 and s_ready=1 -> one word: s_data=32'h44332211, s_keep=F, s_last=1, s_valid high 1 cycle after byte 44.
REQ-033 Continuous bytes 00..07 with s_valid and s_ready held 1 -> words 32'h03020100 then 32'h07060504 with no s_valid gap beyond formation; m_ready stays 1 throughout.
REQ-034 Bytes AA,BB with m_last on BB -> s_data=32'h0000BBAA, s_keep=4'b0011, s_last=1; the next byte CC with m_last lands in lane 0 with s_keep=4'b0001.
REQ-035 Word pending with s_ready=0 for 5 cycles -> m_ready=0 and s_* stable for those 5 cycles; s_ready=1 -> word accepted and m_ready=1 in the same cycle.
REQ-036 Reset asserted after 2 bytes accepted -> all outputs 0 asynchronously; the next 4 bytes 01..04 give 32'h04030201.
REQ-037 LSB_FIRST=0; bytes 11,22,33,44 -> s_data=32'h11223344, s_keep=F.

Source files
------------

// File: rtl/axis8to32.sv
// Packs an 8-bit byte stream into 32-bit words. The completing byte (4th byte or m_last) loads the output register on the same edge.
// A pending output word stalls input only while s_ready is low: m_ready = ~s_valid | s_ready.
module axis8to32 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic [7:0]  m_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic        m_last,
  output logic [31:0] s_data,
  output logic [3:0]  s_keep,
  output logic        s_last,
  output logic        s_valid,
  input  logic        s_ready
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  keep_q, keep_d;
  logic        last_q, last_d;
  logic        vld_q, vld_d;

  logic        byte_acc;
  logic        word_acc;
  logic        complete;
  logic [1:0]  lane;
  logic [31:0] placed;
  logic [3:0]  keep_lsb;
  logic [3:0]  keep_new;

  assign m_ready  = ~vld_q | s_ready;
  assign byte_acc = m_valid & m_ready;
  assign word_acc = vld_q & s_ready;
  assign complete = byte_acc & ((cnt_q == 2'd3) | m_last);
  assign lane     = LSB_FIRST ? cnt_q : (2'd3 - cnt_q);
  assign placed   = {24'h0, m_data} << {lane, 3'b000};

  // Keep mask grows from the first-byte lane; MSB-first is the bit-reversed LSB-first mask.
  always_comb begin
    keep_lsb = 4'b1111;
    case (cnt_q)
      2'd0:    keep_lsb = 4'b0001;
      2'd1:    keep_lsb = 4'b0011;
      2'd2:    keep_lsb = 4'b0111;
      default: keep_lsb = 4'b1111;
    endcase
  end

  assign keep_new = LSB_FIRST ? keep_lsb
                              : {keep_lsb[0], keep_lsb[1], keep_lsb[2], keep_lsb[3]};

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dat_d  = dat_q;
    keep_d = keep_q;
    last_d = last_q;
    vld_d  = vld_q;
    if (word_acc) begin
      vld_d = 1'b0;
    end
    if (complete) begin
      dat_d  = acc_q | placed;
      keep_d = keep_new;
      last_d = m_last;
      vld_d  = 1'b1;
      cnt_d  = 2'd0;
      acc_d  = 32'h0;
    end else if (byte_acc) begin
      acc_d = acc_q | placed;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      cnt_q  <= 2'd0;
      acc_q  <= 32'h0;
      dat_q  <= 32'h0;
      keep_q <= 4'h0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dat_q  <= dat_d;
      keep_q <= keep_d;
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end

  assign s_data  = dat_q;
  assign s_keep  = keep_q;
  assign s_last  = last_q;
  assign s_valid = vld_q;

endmodule

// File: tb/tb_axis8to32.sv
// Drives both byte orders from one stimulus stream and checks them against a packet-level model.
module tb_axis8to32;

  logic       clk = 1'b0;
  logic       rstf = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_last = 1'b0;
  logic       s_ready = 1'b0;

  logic        m_ready_l, m_ready_m;
  logic [31:0] s_data_l, s_data_m;
  logic [3:0]  s_keep_l, s_keep_m;
  logic        s_last_l, s_last_m;
  logic        s_valid_l, s_valid_m;

  axis8to32 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rstf(rstf), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready_l),
    .m_last(m_last), .s_data(s_data_l), .s_keep(s_keep_l), .s_last(s_last_l),
    .s_valid(s_valid_l), .s_ready(s_ready)
  );

  axis8to32 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rstf(rstf), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready_m),
    .m_last(m_last), .s_data(s_data_m), .s_keep(s_keep_m), .s_last(s_last_m),
    .s_valid(s_valid_m), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference: bytes gathered into a list; a word is formed from the list when it holds 4 bytes or sees last.
  logic [7:0]  byte_q[$];
  logic        pend_v;
  logic [31:0] pend_dl, pend_dm;
  logic [3:0]  pend_kl, pend_km;
  logic        pend_last;
  int          words_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    byte_q.delete();
    pend_v    = 1'b0;
    pend_dl   = 32'h0;
    pend_dm   = 32'h0;
    pend_kl   = 4'h0;
    pend_km   = 4'h0;
    pend_last = 1'b0;
  endtask

  task automatic form_word(input logic last);
    pend_dl = 32'h0;
    pend_dm = 32'h0;
    pend_kl = 4'h0;
    pend_km = 4'h0;
    for (int i = 0; i < byte_q.size(); i++) begin
      pend_dl = pend_dl | (32'(byte_q[i]) << (8 * i));
      pend_dm = pend_dm | (32'(byte_q[i]) << (8 * (3 - i)));
      pend_kl[i]     = 1'b1;
      pend_km[3 - i] = 1'b1;
    end
    pend_last = last;
    pend_v    = 1'b1;
    byte_q.delete();
  endtask

  task automatic check_outputs();
    logic exp_mr;
    exp_mr = !pend_v || s_ready;
    check("m_ready_l", {31'h0, m_ready_l}, {31'h0, exp_mr});
    check("m_ready_m", {31'h0, m_ready_m}, {31'h0, exp_mr});
    check("s_valid_l", {31'h0, s_valid_l}, {31'h0, pend_v});
    check("s_valid_m", {31'h0, s_valid_m}, {31'h0, pend_v});
    check("s_data_l", s_data_l, pend_dl);
    check("s_data_m", s_data_m, pend_dm);
    check("s_keep_l", {28'h0, s_keep_l}, {28'h0, pend_kl});
    check("s_keep_m", {28'h0, s_keep_m}, {28'h0, pend_km});
    check("s_last_l", {31'h0, s_last_l}, {31'h0, pend_last});
    check("s_last_m", {31'h0, s_last_m}, {31'h0, pend_last});
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic sr);
    logic bt, wt;
    @(negedge clk);
    m_valid = v;
    m_data  = d;
    m_last  = l;
    s_ready = sr;
    #1;
    check_outputs();
    bt = v && (!pend_v || sr);
    wt = pend_v && sr;
    @(posedge clk);
    #1;
    if (wt) begin
      pend_v = 1'b0;
      words_seen++;
    end
    if (bt) begin
      byte_q.push_back(d);
      if (byte_q.size() == 4 || l) form_word(l);
    end
    m_valid = 1'b0;
    m_data  = 8'($urandom);
    m_last  = 1'($urandom);
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rstf = 1'b1;

    cyc(1'b1, 8'h11, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b1);
    cyc(1'b1, 8'h33, 1'b0, 1'b1);
    check("held_before_last", {31'h0, s_valid_l}, 32'h0);
    cyc(1'b1, 8'h44, 1'b1, 1'b1);
    check("r032_vld", {31'h0, s_valid_l}, 32'h1);
    check("r032_dat", s_data_l, 32'h44332211);
    check("r032_keep", {28'h0, s_keep_l}, 32'hF);
    check("r032_last", {31'h0, s_last_l}, 32'h1);
    check("r037_dat", s_data_m, 32'h11223344);
    check("r037_keep", {28'h0, s_keep_m}, 32'hF);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b1);
      if (i == 3) check("r033_w0", s_data_l, 32'h03020100);
      if (i == 7) check("r033_w1", s_data_l, 32'h07060504);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    cyc(1'b1, 8'hBB, 1'b1, 1'b1);
    check("r034_dat", s_data_l, 32'h0000BBAA);
    check("r034_keep", {28'h0, s_keep_l}, 32'h3);
    check("r034_dat_m", s_data_m, 32'hAABB0000);
    check("r034_keep_m", {28'h0, s_keep_m}, 32'hC);
    cyc(1'b1, 8'hCC, 1'b1, 1'b1);
    check("r034_cc", s_data_l, 32'h000000CC);
    check("r034_cc_keep", {28'h0, s_keep_l}, 32'h1);
    check("r034_cc_m", s_data_m, 32'hCC000000);
    check("r034_cc_keep_m", {28'h0, s_keep_m}, 32'h8);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i + 8'h60), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    cyc(1'b1, 8'h66, 1'b0, 1'b1);

    #2;
    rstf = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rstf = 1'b1;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
    check("r036_dat", s_data_l, 32'h04030201);
    check("r036_dat_m", s_data_m, 32'h01020304);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) != 0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("words_drained", {31'h0, pend_v}, 32'h0);
    check("words_seen_min", {31'h0, words_seen > 100}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
